cla_pipelined_addsub: RTL and testbench
=======================================

# cla_pipelined_addsub

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups. Each group feeds a second-level lookahead unit that uses the group propagate/generate terms. Carries are registered between stages so the datapath width can scale without lengthening the critical path. The block sits in the execute stage as the ALU add/sub/compare engine, with a valid/ready handshake and full backpressure, and it produces C/V/Z/N flags.

## Interface
- `WIDTH`, default 32: operand width in bits. Must be a multiple of 4 and ≥ 8.
- `STAGES`, default 4: pipeline depth. Must divide `WIDTH/4` exactly; legal range 1..`WIDTH/4`.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: operand beat valid.
- `in_ready` output, 1 bit: the block can accept a beat this cycle.
- `in_a` input, `WIDTH` bits: operand A.
- `in_b` input, `WIDTH` bits: operand B.
- `in_sub` input, 1 bit: 0 = A+B, 1 = A−B.
- `in_sat` input, 1 bit: request signed saturation. Used only when `CLA_ADDSUB_SAT_EN` is defined.
- `out_valid` output, 1 bit: result valid.
- `out_ready` input, 1 bit: the consumer accepts the result.
- `out_sum` output, `WIDTH` bits: result.
- `out_c` output, 1 bit: carry out of the MSB. For subtract, 1 = no borrow.
- `out_v` output, 1 bit: signed overflow.
- `out_z` output, 1 bit: `out_sum` == 0.
- `out_n` output, 1 bit: `out_sum[WIDTH-1]`.

## Operation
- **Subtract:** B is inverted and carry-in is forced to 1. There is no external carry-in.
- **Group structure:**
  - The operand is split into `WIDTH/4` 4-bit groups.
  - Each group computes per-bit p = a^b and g = a&b, internal carries c1..c3 by lookahead, and group P/G.
  - Stage k, counting 0..`STAGES`-1 from the LSB, handles groups k·n to k·n+n−1, where n = `WIDTH/(4·STAGES)`.
  - Inside a stage, group carries come from a second-level lookahead over the group P/G terms and the stage carry-in.
- **Stage registers.** Each stage register holds:
  - valid bit;
  - sum bits resolved so far;
  - unprocessed upper bits of A and inverted B;
  - the carry into the next stage;
  - the sub and sat tags.
- **Flags.** Computed combinationally from the final stage register:
  - C = carry out of bit `WIDTH`-1.
  - V = carry into MSB XOR carry out of MSB.
  - Z and N are taken from the delivered `out_sum`, after any saturation.
- **Handshake:**
  - A beat transfers on `in_valid && in_ready`. A result transfers on `out_valid && out_ready`.
  - Stage k advances when its successor is empty or advancing: ready_k = !valid_{k+1} || ready_{k+1}.
  - The last stage advances on `out_ready || !out_valid`.
  - `in_ready` = stage-0 ready, computed combinationally. It depends on `out_ready` with no bubble.
  - The pipeline holds up to `STAGES` results. Results are delivered in acceptance order and are never dropped or duplicated.
  - While a stage is stalled, its contents hold and `out_*` stay stable.
- **Reset:**
  - Asserting `rst_n` low at any time, including mid-operation, flushes the pipeline immediately and asynchronously.
  - During and after reset: all valid bits 0; `out_valid`=0; `out_sum`=0; `out_c`=`out_v`=`out_n`=0; `out_z`=1.
  - `in_ready`=1 once `rst_n` is high, since the pipeline is empty.
- **Data hygiene:** inputs are ignored when `in_valid`=0, and X on them must not propagate into valid state.

## Timing
- **Latency:** exactly `STAGES` cycles from acceptance to `out_valid`, with no stall.
- **Throughput:** one result per cycle while `out_ready`=1.
- **Stage 1 case:** `STAGES`=1 gives a single registered full-width lookahead adder.
- **Simultaneous accept and deliver** on a full pipeline: both complete in the same cycle and occupancy is unchanged.
- **Critical path per stage:** one 4-bit group lookahead, plus n-group second-level lookahead, plus the sum XOR.

## Configuration
- `CLA_ADDSUB_SAT_EN` defined:
  - A beat with `in_sat`=1 and V=1 yields 0x7FF…F if the true result is positive, and 0x800…0 if negative.
  - `out_v` still reports 1, and `out_c` reports the raw carry.
  - Z and N follow the saturated value.
- `CLA_ADDSUB_SAT_EN` undefined: `in_sat` is ignored, no saturation logic is built, and `out_sum` is always the wrapped result.

## Test plan
All scenarios use WIDTH=32, STAGES=4.
- **Unsigned wrap:** 0xFFFFFFFF + 0x00000001 → after 4 cycles `out_sum`=0x00000000, C=1, Z=1, V=0, N=0.
- **Signed overflow:**
  - 0x7FFFFFFF + 0x00000001 with `in_sat`=0 → 0x80000000, V=1, N=1, C=0.
  - Same with `in_sat`=1 and `CLA_ADDSUB_SAT_EN` defined → 0x7FFFFFFF, V=1, N=0.
- **Subtract and compare:**
  - 5 − 7 → 0xFFFFFFFE, C=0, N=1, V=0.
  - 7 − 7 → 0, C=1, Z=1.
- **Backpressure:**
  - Hold `out_ready`=0 while offering beats of A=i (i=1..6), B=1, add, every cycle → exactly 4 accepted, then `in_ready`=0 and `out_sum`=2 held stable.
  - Raise `out_ready` → 2,3,4,5,6,7 delivered in order, one per cycle.
- **Full-pipeline pass-through:** with the pipeline full and `in_valid`=`out_ready`=1 continuously, one accept and one delivery occur every cycle with no bubble.
- **Reset mid-operation:** pulse `rst_n` low for a partial cycle with 3 beats in flight → `out_valid`=0 immediately, and no stale result appears afterwards. The next beat, 0x12340000 + 0x00005678, yields 0x12345678 after exactly 4 cycles.

Source files
------------

// File: rtl/cla_pipelined_addsub.sv
// -----------------------------------------------------------------------------
// cla_pipelined_addsub
//
// Pipelined carry-lookahead adder/subtractor for the execute-stage ALU.
// The operands are split into 4-bit lookahead groups. Each pipeline stage
// resolves WIDTH/STAGES bits using first-level group lookahead and a
// second-level lookahead across that stage's groups. The carry into the next
// stage is registered. Results carry C/V/Z/N flags and move through a
// valid/ready handshake with full backpressure.
//
// Optional feature macro: CLA_ADDSUB_SAT_EN
//   When defined, a beat with in_sat=1 that overflows is clamped to the
//   signed max or min value. When undefined, in_sat is ignored and no
//   saturation logic is built.
//
// Parameters
//   WIDTH   operand width. Must be a multiple of 4 and >= 8.
//   STAGES  pipeline depth. Must divide WIDTH/4; range 1..WIDTH/4.
//
// Ports
//   clk, rst_n          clock (rising edge) and async active-low reset
//   in_valid/in_ready   operand beat handshake
//   in_a, in_b          operands
//   in_sub              0: A+B, 1: A-B
//   in_sat              saturation request (only with CLA_ADDSUB_SAT_EN)
//   out_valid/out_ready result handshake
//   out_sum             result (saturated if requested and enabled)
//   out_c               carry out of the MSB (for subtract, 1 = no borrow)
//   out_v               signed overflow
//   out_z, out_n        zero / negative, taken from the delivered out_sum
// -----------------------------------------------------------------------------
module cla_pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_c,
    output logic             out_v,
    output logic             out_z,
    output logic             out_n
);

    localparam int NGRP = WIDTH / 4;       // total 4-bit groups
    localparam int GPS  = NGRP / STAGES;   // groups per stage
    localparam int SW   = WIDTH / STAGES;  // bits resolved per stage
    localparam int LAST = STAGES - 1;

    typedef struct packed {
        logic [WIDTH-1:0] sum;   // sum bits resolved so far
        logic             cout;  // carry out of this stage's slice
        logic             cmsb;  // carry into the top bit of this slice
    } stage_res_t;

    // One stage of lookahead over the bit slice [k*SW +: SW].
    // Bits of sum_in below the slice are passed through untouched.
    function automatic stage_res_t stage_calc(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] sum_in,
        input logic             cin,
        input int               k
    );
        stage_res_t     r;
        logic [GPS:0]   gc;   // carries into each group, gc[GPS] = stage carry out
        logic [GPS-1:0] gp;
        logic [GPS-1:0] gg;
        logic [3:0]     p;
        logic [3:0]     g;
        logic [3:0]     c;
        logic           t;
        logic           pr;
        int             base;

        r.sum  = sum_in;
        r.cmsb = 1'b0;
        r.cout = 1'b0;

        // First level: group propagate / generate.
        for (int j = 0; j < GPS; j++) begin
            base  = k * SW + 4 * j;
            p     = a[base +: 4] ^ b[base +: 4];
            g     = a[base +: 4] & b[base +: 4];
            gp[j] = &p;
            gg[j] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]);
        end

        // Second level: each group carry is a flat sum of products over the
        // lower groups' G terms and the stage carry-in, not a ripple chain.
        gc[0] = cin;
        for (int j = 1; j <= GPS; j++) begin
            t  = 1'b0;
            pr = 1'b1;
            for (int i = j - 1; i >= 0; i--) begin
                t  = t | (gg[i] & pr);
                pr = pr & gp[i];
            end
            gc[j] = t | (pr & cin);
        end

        // Group-internal carries c1..c3 and the sum XOR.
        for (int j = 0; j < GPS; j++) begin
            base = k * SW + 4 * j;
            p    = a[base +: 4] ^ b[base +: 4];
            g    = a[base +: 4] & b[base +: 4];
            c[0] = gc[j];
            c[1] = g[0] | (p[0] & gc[j]);
            c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & gc[j]);
            c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & gc[j]);
            r.sum[base +: 4] = p ^ c;
            // The top group is visited last, so this ends up as the carry
            // into the slice's MSB; only the final stage's value is used (V).
            r.cmsb = c[3];
        end

        r.cout = gc[GPS];
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic [STAGES-1:0] vld_q,  vld_d;
    logic [STAGES-1:0] c_q,    c_d;
    logic [STAGES-1:0] cmsb_q, cmsb_d;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];   // B already inverted for subtract
    logic [WIDTH-1:0]  b_d   [STAGES];
`ifdef CLA_ADDSUB_SAT_EN
    logic [STAGES-1:0] sat_q, sat_d;
`endif

    // Subtract is fully absorbed at entry (inverted B, carry-in of 1), so
    // later stages need no sub tag.
    logic [STAGES-1:0] src_vld;
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] src_sat;
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];
    stage_res_t        res     [STAGES];
    logic [STAGES-1:0] adv;   // stage register may load this cycle

    // Stage inputs: stage 0 from the ports, stage k from register k-1.
    always_comb begin
        src_vld[0] = in_valid;
        src_a[0]   = in_a;
        src_b[0]   = in_sub ? ~in_b : in_b;
        src_sum[0] = '0;
        src_c[0]   = in_sub;
        src_sat[0] = in_sat;
        for (int k = 1; k < STAGES; k++) begin
            src_vld[k] = vld_q[k-1];
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_sum[k] = sum_q[k-1];
            src_c[k]   = c_q[k-1];
`ifdef CLA_ADDSUB_SAT_EN
            src_sat[k] = sat_q[k-1];
`else
            src_sat[k] = 1'b0;
`endif
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            res[k] = stage_calc(src_a[k], src_b[k], src_sum[k], src_c[k], k);
        end
    end

    // Backpressure chain: a register may load when it is empty or its
    // contents leave this cycle. Purely combinational, so a full pipeline
    // accepts in the same cycle that it delivers.
    always_comb begin
        adv       = '0;
        adv[LAST] = !vld_q[LAST] || out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            adv[k] = !vld_q[k] || adv[k+1];
        end
    end

    assign in_ready = adv[0];

    // Data fields load only with a valid beat, so idle-cycle garbage on the
    // inputs never reaches the pipeline state.
    always_comb begin
        vld_d  = vld_q;
        c_d    = c_q;
        cmsb_d = cmsb_q;
`ifdef CLA_ADDSUB_SAT_EN
        sat_d  = sat_q;
`endif
        for (int k = 0; k < STAGES; k++) begin
            sum_d[k] = sum_q[k];
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            if (adv[k]) begin
                vld_d[k] = src_vld[k];
            end
            if (adv[k] && src_vld[k]) begin
                sum_d[k]  = res[k].sum;
                c_d[k]    = res[k].cout;
                cmsb_d[k] = res[k].cmsb;
                a_d[k]    = src_a[k];
                b_d[k]    = src_b[k];
`ifdef CLA_ADDSUB_SAT_EN
                sat_d[k]  = src_sat[k];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            c_q    <= '0;
            cmsb_q <= '0;
`ifdef CLA_ADDSUB_SAT_EN
            sat_q  <= '0;
`endif
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            c_q    <= c_d;
            cmsb_q <= cmsb_d;
`ifdef CLA_ADDSUB_SAT_EN
            sat_q  <= sat_d;
`endif
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= sum_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output and flags from the final stage register
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] raw_sum;

    assign raw_sum   = sum_q[LAST];
    assign out_valid = vld_q[LAST];
    assign out_c     = c_q[LAST];
    assign out_v     = c_q[LAST] ^ cmsb_q[LAST];

`ifdef CLA_ADDSUB_SAT_EN
    // On overflow the wrapped MSB is the inverse of the true sign: a wrapped
    // negative means the true result was positive, so clamp to max.
    always_comb begin
        out_sum = raw_sum;
        if (sat_q[LAST] && out_v) begin
            out_sum = raw_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                       : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end
`else
    logic unused_sat;
    assign unused_sat = ^{in_sat, src_sat};
    assign out_sum    = raw_sum;
`endif

    assign out_z = ~|out_sum;
    assign out_n = out_sum[WIDTH-1];

endmodule

// File: tb/tb_cla_pipelined_addsub.sv
module tb_cla_pipelined_addsub;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
`ifdef CLA_ADDSUB_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_sub = 1'b0;
    logic             in_sat = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic             out_c, out_v, out_z, out_n;

    typedef struct packed {
        logic [31:0] sum;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    cla_pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_sat    (in_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_c     (out_c),
        .out_v     (out_v),
        .out_z     (out_z),
        .out_n     (out_n)
    );

    // Reference: plain signed/unsigned arithmetic on 64-bit integers.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic sat);
        exp_t            e;
        longint          sa, sb, sr;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (sub) begin
            sr  = sa - sb;
            e.c = (ua >= ub);
        end else begin
            sr  = sa + sb;
            e.c = ((ua + ub) > 64'hFFFF_FFFF);
        end
        e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.sum = (SAT_BUILD && sat && e.v) ? ((sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000)
                                          : sr[31:0];
        e.z   = (e.sum == 32'd0);
        e.n   = e.sum[31];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, sample 1ns later, score, wait posedge.
    task automatic cycle(input logic vld, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic sat, input logic ordy,
                         output logic acc, output logic dlv, output logic [31:0] obs_sum);
        exp_t e;
        @(negedge clk);
        in_valid  = vld;
        in_a      = vld ? a : $urandom();
        in_b      = vld ? b : $urandom();
        in_sub    = vld ? sub : 1'($urandom_range(0, 1));
        in_sat    = vld ? sat : 1'($urandom_range(0, 1));
        out_ready = ordy;
        #1;
        acc     = in_valid && in_ready;
        dlv     = out_valid && out_ready;
        obs_sum = out_sum;
        if (q.size() == 0) begin
            chk("out_valid_when_empty", {63'd0, out_valid}, 64'd0);
        end else if (out_valid) begin
            e = q[0];
            chk("sb_sum", out_sum, e.sum);
            chk("sb_c", out_c, e.c);
            chk("sb_v", out_v, e.v);
            chk("sb_z", out_z, e.z);
            chk("sb_n", out_n, e.n);
            if (dlv) void'(q.pop_front());
        end
        if (acc) q.push_back(model(a, b, sub, sat));
        @(posedge clk);
    endtask

    // Single isolated beat: checks acceptance, exact latency and flags.
    task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic sat);
        exp_t e;
        int   lat;
        e = model(a, b, sub, sat);
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_sat    = sat;
        out_ready = 1'b1;
        #1 chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, STAGES);
        chk({tag, "_sum"}, out_sum, e.sum);
        chk({tag, "_c"}, out_c, e.c);
        chk({tag, "_v"}, out_v, e.v);
        chk({tag, "_z"}, out_z, e.z);
        chk({tag, "_n"}, out_n, e.n);
        @(posedge clk);
        #1 chk({tag, "_drained"}, out_valid, 0);
    endtask

    initial begin
        logic        acc, dlv;
        logic [31:0] obs;
        int          cnt;
        int          idx;

        // Reset state
        #2 rst_n = 1'b0;
        #10;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_c", out_c, 0);
        chk("rst_out_v", out_v, 0);
        chk("rst_out_n", out_n, 0);
        chk("rst_out_z", out_z, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1);

        // Directed arithmetic cases
        single("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        single("ovf_nosat", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        single("ovf_sat", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        single("ovf_neg_sat", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        single("sub_5_7", 32'd5, 32'd7, 1'b1, 1'b0);
        single("sub_7_7", 32'd7, 32'd7, 1'b1, 1'b0);
        single("carry_chain", 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0);

        // Backpressure: out_ready low, offer A=i, B=1 until accepted
        cnt = 0;
        idx = 1;
        for (int t = 0; t < 8; t++) begin
            cycle(1'b1, idx, 32'd1, 1'b0, 1'b0, 1'b0, acc, dlv, obs);
            if (acc) begin
                cnt++;
                idx++;
            end
        end
        chk("bp_accepted", cnt, STAGES);
        #1;
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_head_held", out_sum, 32'd2);
        for (int t = 0; t < 6; t++) begin
            cycle(idx <= 6, idx, 32'd1, 1'b0, 1'b0, 1'b1, acc, dlv, obs);
            chk("bp_deliver", dlv, 1);
            chk("bp_order", obs, 32'(t + 2));
            if (acc) idx++;
        end
        chk("bp_all_accepted", idx, 7);

        // Continuous pass-through: no bubble once full
        for (int t = 0; t < 40; t++) begin
            cycle(1'b1, $urandom(), $urandom(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b1, acc, dlv, obs);
            if (t >= STAGES) begin
                chk("pt_accept", acc, 1);
                chk("pt_deliver", dlv, 1);
            end
        end

        // Random traffic with random backpressure
        for (int t = 0; t < 300; t++) begin
            cycle(1'($urandom_range(0, 1)), $urandom(), $urandom(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), acc, dlv, obs);
        end
        cnt = 0;
        while (q.size() > 0 && cnt < 50) begin
            cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc, dlv, obs);
            cnt++;
        end
        chk("drain_empty", q.size(), 0);

        // Reset mid-operation with 3 beats in flight
        for (int t = 0; t < 3; t++) begin
            cycle(1'b1, 32'(100 + t), 32'd1, 1'b0, 1'b0, 1'b0, acc, dlv, obs);
        end
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, acc, dlv, obs);
        #1 chk("pre_rst_out_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_sum", out_sum, 0);
        chk("midrst_out_z", out_z, 1);
        q.delete();
        #1 rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc, dlv, obs);
        end
        single("post_rst", 32'h1234_0000, 32'h0000_5678, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
